// File: rtl/axil_regfile.sv
// axil_regfile: AXI-lite slave terminating writes/reads into a bank of REG_COUNT control/status registers.
// Optional AXIL_REGFILE_RD_PIPE_EN adds a registered read decode stage (2-cycle read latency).
`timescale 1ns/1ps
module axil_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int REG_COUNT = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            s_axil_awaddr,
  input  logic [2:0]                       s_axil_awprot,
  input  logic                             s_axil_awvalid,
  output logic                             s_axil_awready,
  input  logic [DATA_WIDTH-1:0]            s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]            s_axil_wstrb,
  input  logic                             s_axil_wvalid,
  output logic                             s_axil_wready,
  output logic [1:0]                       s_axil_bresp,
  output logic                             s_axil_bvalid,
  input  logic                             s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]            s_axil_araddr,
  input  logic [2:0]                       s_axil_arprot,
  input  logic                             s_axil_arvalid,
  output logic                             s_axil_arready,
  output logic [DATA_WIDTH-1:0]            s_axil_rdata,
  output logic [1:0]                       s_axil_rresp,
  output logic                             s_axil_rvalid,
  input  logic                             s_axil_rready,
  output logic [REG_COUNT*DATA_WIDTH-1:0]  reg_out,
  output logic [REG_COUNT-1:0]             reg_wr
);
  localparam int AL = $clog2(STRB_WIDTH);
  localparam int IW = REG_COUNT > 1 ? $clog2(REG_COUNT) : 1;
  localparam logic [31:0] RC = 32'(REG_COUNT);
  logic                  rdy_q;
  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [REG_COUNT-1:0]  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic                  aw_hs, w_hs, ar_hs, commit, w_hit, rd_go;
  logic [IW-1:0]         w_idx;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused;
  function automatic logic hit_f(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a >> AL) < RC;
  endfunction
  assign unused = ^{s_axil_awprot, s_axil_arprot};
  assign s_axil_awready = rdy_q & !aw_full_q;
  assign s_axil_wready = rdy_q & !w_full_q;
  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs = s_axil_wvalid & s_axil_wready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;
  assign commit = aw_full_q & w_full_q & (!bvalid_q | s_axil_bready);
  assign w_idx = aw_addr_q[AL +: IW];
  assign w_hit = hit_f(aw_addr_q);
`ifdef AXIL_REGFILE_RD_PIPE_EN
  logic                  s_v_q, s_v_d;
  logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
  assign s_axil_arready = rdy_q & !s_v_q & (!rvalid_q | s_axil_rready);
  assign rd_go = s_v_q & (!rvalid_q | s_axil_rready);
  assign rd_addr = s_addr_q;
  assign rd_word = regs_d[rd_addr[AL +: IW]];
  // Decode stage holds the accepted read address until the output register is free
  always_comb begin
    s_v_d = ar_hs | (s_v_q & !rd_go);
    s_addr_d = ar_hs ? s_axil_araddr : s_addr_q;
  end
  // Decode stage state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_v_q <= 1'b0;
      s_addr_q <= '0;
    end else begin
      s_v_q <= s_v_d;
      s_addr_q <= s_addr_d;
    end
  end
`else
  assign s_axil_arready = rdy_q & (!rvalid_q | s_axil_rready);
  assign rd_go = ar_hs;
  assign rd_addr = s_axil_araddr;
  assign rd_word = regs_q[rd_addr[AL +: IW]];
`endif
  // Holding registers, write response and read response next state
  always_comb begin
    aw_full_d = commit ? 1'b0 : (aw_hs | aw_full_q);
    aw_addr_d = aw_hs ? s_axil_awaddr : aw_addr_q;
    w_full_d = commit ? 1'b0 : (w_hs | w_full_q);
    w_data_d = w_hs ? s_axil_wdata : w_data_q;
    w_strb_d = w_hs ? s_axil_wstrb : w_strb_q;
    bvalid_d = commit | (bvalid_q & !s_axil_bready);
    bresp_d = commit ? (w_hit ? 2'b00 : 2'b10) : bresp_q;
    rvalid_d = rd_go | (rvalid_q & !s_axil_rready);
    rresp_d = rd_go ? (hit_f(rd_addr) ? 2'b00 : 2'b10) : rresp_q;
    rdata_d = rd_go ? (hit_f(rd_addr) ? rd_word : '0) : rdata_q;
  end
  // Byte-masked register update and one-hot write pulse on commit
  always_comb begin
    wr_d = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && w_hit && w_idx == IW'(i)) begin
        wr_d[i] = 1'b1;
        for (int b = 0; b < STRB_WIDTH; b++)
          if (w_strb_q[b]) regs_d[i][b*8 +: 8] = w_data_q[b*8 +: 8];
      end
    end
  end
  // Channel control state; rdy_q keeps ready low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q <= 2'b00;
      rdata_q <= '0;
      wr_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q <= w_full_d;
      w_data_q <= w_data_d;
      w_strb_q <= w_strb_d;
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
      wr_q <= wr_d;
    end
  end
  // Register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= regs_d[i];
    end
  end
  for (genvar i = 0; i < REG_COUNT; i++) begin : g_out
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end
  assign reg_wr = wr_q;
  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rresp = rresp_q;
  assign s_axil_rdata = rdata_q;
endmodule

// File: tb/tb_axil_regfile.sv
// tb_axil_regfile: directed scoreboard bench for axil_regfile (default parameters).
`timescale 1ns/1ps
module tb_axil_regfile;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  s_axil_awaddr, s_axil_araddr;
  logic [2:0]   s_axil_awprot, s_axil_arprot;
  logic         s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [31:0]  s_axil_wdata, s_axil_rdata;
  logic [3:0]   s_axil_wstrb;
  logic [1:0]   s_axil_bresp, s_axil_rresp;
  logic         s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic         s_axil_rvalid, s_axil_rready;
  logic [511:0] reg_out;
  logic [15:0]  reg_wr;
  int           checks = 0;
  int           errors = 0;
  logic [1:0]   bq[$];
  logic [33:0]  rq[$];
  logic [31:0]  mdl [16];

  axil_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .reg_out(reg_out), .reg_wr(reg_wr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  task automatic tmo(input string n);
    checks++;
    errors++;
    $display("FAIL %s timeout actual=no handshake expected=handshake within 50 cycles", n);
  endtask

  function automatic logic [511:0] packm();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = mdl[i];
    return v;
  endfunction

  task automatic send_aw(input logic [15:0] a);
    int n = 0;
    s_axil_awaddr = a;
    s_axil_awvalid = 1'b1;
    @(negedge clk);
    while (!s_axil_awready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) tmo("aw_handshake");
    @(posedge clk);
    #1 s_axil_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_axil_wdata = d;
    s_axil_wstrb = s;
    s_axil_wvalid = 1'b1;
    @(negedge clk);
    while (!s_axil_wready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) tmo("w_handshake");
    @(posedge clk);
    #1 s_axil_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [15:0] a);
    int n = 0;
    s_axil_araddr = a;
    s_axil_arvalid = 1'b1;
    @(negedge clk);
    while (!s_axil_arready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) tmo("ar_handshake");
    @(posedge clk);
    #1 s_axil_arvalid = 1'b0;
  endtask

  task automatic write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
    bq.push_back(r);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic read(input logic [15:0] a, input logic [33:0] e);
    rq.push_back(e);
    send_ar(a);
  endtask

  task automatic drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) tmo("drain");
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && s_axil_bvalid && s_axil_bready) begin
      if (bq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected actual=bvalid with bresp=%0h expected=no response", s_axil_bresp);
      end else chk("bresp", s_axil_bresp, bq.pop_front());
    end
    if (rst_n && s_axil_rvalid && s_axil_rready) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL r_unexpected actual=rvalid with rdata=%0h expected=no response", s_axil_rdata);
      end else chk("rresp_rdata", {s_axil_rresp, s_axil_rdata}, rq.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 0;
    s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 0;
    s_axil_bready = 1; s_axil_rready = 1;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 0);
    chk("rst_valid", {s_axil_bvalid, s_axil_rvalid}, 0);
    chk("rst_resp_data", {s_axil_bresp, s_axil_rresp, s_axil_rdata}, 0);
    chk("rst_regs", reg_out, 0);
    chk("rst_wr", reg_wr, 0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    // same-cycle AW/W, response two cycles after the handshake
    @(posedge clk); #1;
    write(16'h0004, 32'hDEADBEEF, 4'hF, 2'b00);
    mdl[1] = 32'hDEADBEEF;
    @(negedge clk);
    chk("b_not_early", s_axil_bvalid, 0);
    @(negedge clk);
    chk("b_latency", s_axil_bvalid, 1);
    chk("wr_pulse", reg_wr, 16'h0002);
    chk("reg1", reg_out[63:32], 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_pulse_once", reg_wr, 0);
    drain();
    // W three cycles ahead of AW, byte strobes
    write(16'h0008, 32'hFFFFFFFF, 4'hF, 2'b00);
    drain();
    bq.push_back(2'b00);
    send_w(32'h12345678, 4'b0101);
    @(negedge clk);
    chk("w_held", {s_axil_wready, s_axil_awready, s_axil_bvalid}, 3'b010);
    repeat (3) @(posedge clk);
    #1;
    send_aw(16'h0008);
    drain();
    mdl[2] = 32'hFF34FF78;
    chk("reg2_strobe", reg_out[95:64], 32'hFF34FF78);
    // out-of-range read and write
    read(16'h0040, {2'b10, 32'h0});
    drain();
    write(16'h0040, 32'h11111111, 4'hF, 2'b10);
    repeat (4) begin
      @(negedge clk);
      chk("miss_no_wr", reg_wr, 0);
    end
    drain();
    chk("miss_regs", reg_out, packm());
    // read stalled by rready=0, next AR accepted when rready returns
    s_axil_rready = 0;
    read(16'h0004, {2'b00, 32'hDEADBEEF});
    rq.push_back({2'b00, 32'hFF34FF78});
    s_axil_araddr = 16'h0008;
    s_axil_arvalid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_rvalid", s_axil_rvalid, 1);
      chk("stall_rdata", s_axil_rdata, 32'hDEADBEEF);
      chk("stall_arready", s_axil_arready, 0);
    end
    @(posedge clk);
    #1 s_axil_rready = 1;
    @(negedge clk);
    chk("ar_same_cycle", s_axil_arready, 1);
    @(posedge clk);
    #1 s_axil_arvalid = 0;
    drain();
    // AR handshake in the commit cycle of a write to the same register
    write(16'h000C, 32'hA5A5A5A5, 4'hF, 2'b00);
`ifdef AXIL_REGFILE_RD_PIPE_EN
    read(16'h000C, {2'b00, 32'hA5A5A5A5});
`else
    read(16'h000C, {2'b00, 32'h00000000});
`endif
    drain();
    mdl[3] = 32'hA5A5A5A5;
    read(16'h000C, {2'b00, 32'hA5A5A5A5});
    drain();
    chk("regs_before_rst", reg_out, packm());
    // asynchronous reset with B and R responses pending
    s_axil_bready = 0;
    s_axil_rready = 0;
    write(16'h0010, 32'h00000005, 4'hF, 2'b00);
    n = 0;
    while (!s_axil_bvalid && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) tmo("bvalid_wait");
    @(posedge clk); #1;
    send_ar(16'h0004);
    @(negedge clk);
    chk("pending_valid", {s_axil_bvalid, s_axil_rvalid}, 2'b11);
    #2 rst_n = 0;
    #1;
    chk("async_valid_drop", {s_axil_bvalid, s_axil_rvalid}, 0);
    chk("async_regs_clear", reg_out, 0);
    chk("async_ready_low", {s_axil_awready, s_axil_wready, s_axil_arready}, 0);
    bq.delete();
    rq.delete();
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    @(negedge clk);
    rst_n = 1;
    s_axil_bready = 1;
    s_axil_rready = 1;
    @(posedge clk); #1;
    write(16'h0004, 32'h0BADF00D, 4'hF, 2'b00);
    drain();
    mdl[1] = 32'h0BADF00D;
    chk("post_rst_write", reg_out, packm());
    repeat (3) @(posedge clk);
    chk("queues_empty", bq.size() + rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
